// File: rtl/alu_resp_pkg.sv
// Shared types for the ALU responder: op codes, FSM states and the legality check.
package alu_resp_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_MUL = 4'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // Op codes 8..15 are reserved; they answer with c=0 and the error flag.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op[3] == 1'b0);
    endfunction

endpackage

// File: rtl/alu_resp_if.sv
// Request/response bus of the ALU responder: one valid/ready pair per direction.
interface alu_resp_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [3:0]       req_type;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_c;
    logic             rsp_ovf;
    logic             rsp_err;

    // Request generator / result consumer side.
    modport master (
        output req_valid, req_a, req_b, req_type, rsp_ready,
        input  req_ready, rsp_valid, rsp_c, rsp_ovf, rsp_err
    );

    // ALU side.
    modport slave (
        input  req_valid, req_a, req_b, req_type, rsp_ready,
        output req_ready, rsp_valid, rsp_c, rsp_ovf, rsp_err
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle, WIDTH steps.
// The product register starts as {0, b}; each step conditionally adds the
// multiplicand into the upper half and shifts the whole register right by one.
// done and prod_lo/prod_hi are combinational on the final step so the caller
// can capture the finished product on the same edge that performs that step.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     partial;
    logic [2*WIDTH-1:0] prod_next;

    // One shift-add step: add multiplicand when the current multiplier bit is set.
    always_comb begin
        partial   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_next = {partial, prod[WIDTH-1:1]};
    end

    assign done    = busy && (cnt == CW'(WIDTH - 1));
    assign prod_lo = prod_next[WIDTH-1:0];
    assign prod_hi = prod_next[2*WIDTH-1:WIDTH];

    // Load operands on start, then step once per cycle until the last multiplier bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            cnt   <= '0;
            mcand <= '0;
            prod  <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            mcand <= a;
            prod  <= {{WIDTH{1'b0}}, b};
        end else if (busy) begin
            prod <= prod_next;
            cnt  <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_resp.sv
// ALU responder: accepts one operand request at a time and returns the result
// over a valid/ready handshake. Simple ops answer one cycle after acceptance,
// MUL goes through the sequential multiplier. While a result is held, a new
// request is accepted in the same cycle the result is consumed, so simple ops
// stream at one result per cycle.
module alu_resp
    import alu_resp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    alu_resp_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    alu_state_e       state;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_c_q;
    logic             rsp_ovf_q;
    logic             rsp_err_q;

    logic             req_ready_c;
    logic             accept;
    logic             is_mul;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_c;
    logic             alu_ovf;
    logic             alu_err;

    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH-1:0] mul_hi;

    // Ready depends only on state and rsp_ready, never on req_valid.
    assign req_ready_c = (state == IDLE) || ((state == DONE) && bus.rsp_ready);
    assign accept      = bus.req_valid && req_ready_c;
    assign is_mul      = (bus.req_type == ALU_MUL);
    assign mul_start   = accept && is_mul;

    assign sum  = bus.req_a + bus.req_b;
    assign diff = bus.req_a - bus.req_b;

    // Single-cycle datapath for every op except MUL, including the illegal-op answer.
    always_comb begin
        alu_c   = '0;
        alu_ovf = 1'b0;
        alu_err = 1'b0;
        if (!is_legal_op(bus.req_type)) begin
            alu_err = 1'b1;
        end else begin
            case (alu_op_e'(bus.req_type))
                ALU_ADD: begin
                    alu_c   = sum;
                    alu_ovf = (bus.req_a[WIDTH-1] == bus.req_b[WIDTH-1]) &&
                              (sum[WIDTH-1] != bus.req_a[WIDTH-1]);
                end
                ALU_SUB: begin
                    alu_c   = diff;
                    alu_ovf = (bus.req_a[WIDTH-1] != bus.req_b[WIDTH-1]) &&
                              (diff[WIDTH-1] != bus.req_a[WIDTH-1]);
                end
                ALU_AND: alu_c = bus.req_a & bus.req_b;
                ALU_OR:  alu_c = bus.req_a | bus.req_b;
                ALU_XOR: alu_c = bus.req_a ^ bus.req_b;
                ALU_SLL: alu_c = bus.req_a << bus.req_b[SHW-1:0];
                ALU_SRL: alu_c = bus.req_a >> bus.req_b[SHW-1:0];
                default: alu_c = '0;
            endcase
        end
    end

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.req_a),
        .b       (bus.req_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .prod_lo (mul_lo),
        .prod_hi (mul_hi)
    );

    // Control FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_c_q     <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (is_mul) begin
                            state <= MUL;
                        end else begin
                            state       <= DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_c_q     <= alu_c;
                            rsp_ovf_q   <= alu_ovf;
                            rsp_err_q   <= alu_err;
                        end
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        state       <= DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_c_q     <= mul_lo;
                        rsp_ovf_q   <= |mul_hi;
                        rsp_err_q   <= 1'b0;
                    end else if (!mul_busy) begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        if (bus.req_valid) begin
                            if (is_mul) begin
                                state       <= MUL;
                                rsp_valid_q <= 1'b0;
                            end else begin
                                rsp_c_q   <= alu_c;
                                rsp_ovf_q <= alu_ovf;
                                rsp_err_q <= alu_err;
                            end
                        end else begin
                            state       <= IDLE;
                            rsp_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_c     = rsp_c_q;
    assign bus.rsp_ovf   = rsp_ovf_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_resp.sv
// Self-checking bench for alu_resp: vector table, scoreboard monitor and
// hand-written sequences for backpressure, streaming and reset during MUL.
module tb_alu_resp;
    import alu_resp_pkg::*;

    localparam int WIDTH = 32;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        ovf;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic [31:0] c;
        logic        ovf;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    int   rsp_count;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[15];

    alu_resp_if #(.WIDTH(WIDTH)) bus ();

    alu_resp #(
        .WIDTH(WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every response transfer is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            rsp_count++;
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_rsp: got c=%h with empty scoreboard, expected no response",
                         bus.rsp_c);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_c",   bus.rsp_c,          mon_e.c);
                check("rsp_ovf", 32'(bus.rsp_ovf),   32'(mon_e.ovf));
                check("rsp_err", 32'(bus.rsp_err),   32'(mon_e.err));
            end
        end
    end

    // Called just after a rising edge; holds a request until it is accepted.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic ovf, input logic err,
                                 input bit expect_rsp);
        bit accepted;
        exp_t e;
        accepted      = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_type  = op;
        bus.req_a     = a;
        bus.req_b     = b;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                accepted = 1'b1;
                if (expect_rsp) begin
                    e = '{c, ovf, err};
                    sb.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        check("req_accept", 32'(accepted), 32'd1);
    endtask

    // Measures edges from acceptance to the response transfer edge.
    task automatic checkOutput(input int exp_lat, input string name);
        int lat;
        bit got;
        bit ready_hi;
        lat      = 0;
        got      = 1'b0;
        ready_hi = 1'b0;
        while (lat < 100 && !got) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) begin
                got = 1'b1;
            end else if (bus.req_ready) begin
                ready_hi = 1'b1;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        if (exp_lat > 1) begin
            check({name, "_ready_low"}, 32'(ready_hi), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   lat_exp;
        int   k;
        int   cycles;
        int   count0;
        bit   stable;
        bit   quiet;

        tests_run    = 0;
        tests_failed = 0;
        rsp_count    = 0;

        vecs[0]  = '{4'(ALU_ADD), 32'd3,          32'd5,          32'd8,          1'b0, 1'b0};
        vecs[1]  = '{4'(ALU_ADD), 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b1, 1'b0};
        vecs[2]  = '{4'(ALU_SUB), 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[3]  = '{4'(ALU_SUB), 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b1, 1'b0};
        vecs[4]  = '{4'(ALU_AND), 32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234,  1'b0, 1'b0};
        vecs[5]  = '{4'(ALU_OR),  32'h0000_F000,  32'h0000_0F0F,  32'h0000_FF0F,  1'b0, 1'b0};
        vecs[6]  = '{4'(ALU_XOR), 32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555,  1'b0, 1'b0};
        vecs[7]  = '{4'(ALU_SLL), 32'h8000_0001,  32'h0000_0021,  32'h0000_0002,  1'b0, 1'b0};
        vecs[8]  = '{4'(ALU_SRL), 32'h8000_0000,  32'd31,         32'd1,          1'b0, 1'b0};
        vecs[9]  = '{4'(ALU_MUL), 32'd7,          32'd6,          32'd42,         1'b0, 1'b0};
        vecs[10] = '{4'(ALU_MUL), 32'h0001_0000,  32'h0001_0000,  32'd0,          1'b1, 1'b0};
        vecs[11] = '{4'(ALU_MUL), 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b1, 1'b0};
        vecs[12] = '{4'd12,       32'd5,          32'd6,          32'd0,          1'b0, 1'b1};
        vecs[13] = '{4'd15,       32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b0, 1'b1};
        vecs[14] = '{4'(ALU_ADD), 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1'b0};

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_type  = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_c",     bus.rsp_c,          32'd0);
        check("reset_rsp_ovf",   32'(bus.rsp_ovf),   32'd0);
        check("reset_rsp_err",   32'(bus.rsp_err),   32'd0);
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            lat_exp = (vecs[i].op == 4'(ALU_MUL)) ? WIDTH + 1 : 1;
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].ovf, vecs[i].err, 1'b1);
            checkOutput(lat_exp, "vec");
        end

        // Backpressure: result must hold while the consumer stalls.
        bus.rsp_ready = 1'b0;
        applyStimulus(4'(ALU_XOR), 32'h0000_F0F0, 32'h0000_FFFF, 32'h0000_0F0F, 1'b0, 1'b0, 1'b1);
        checkOutput(1, "bp");
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_c !== 32'h0000_0F0F || bus.req_ready) begin
                stable = 1'b0;
            end
        end
        check("bp_hold", 32'(stable), 32'd1);
        check("bp_c", bus.rsp_c, 32'h0000_0F0F);
        @(posedge clk);
        #1;
        count0        = rsp_count;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_single_transfer", 32'(rsp_count - count0), 32'd1);
        check("bp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1;

        // Streaming: 20 back-to-back ADDs, one accept per cycle.
        count0        = rsp_count;
        bus.req_type  = 4'(ALU_ADD);
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_valid = 1'b1;
        k             = 0;
        cycles        = 0;
        while (k < 20 && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (bus.req_ready) begin
                sb.push_back('{32'(3 * k), 1'b0, 1'b0});
                k++;
            end
            @(posedge clk);
            #1;
            bus.req_a = 32'(k);
            bus.req_b = 32'(2 * k);
        end
        bus.req_valid = 1'b0;
        check("stream_cycles", 32'(cycles), 32'd20);
        repeat (3) @(posedge clk);
        #1;
        check("stream_count", 32'(rsp_count - count0), 32'd20);

        check("illegal_then_clean", 32'(sb.size()), 32'd0);

        // Reset during the multiply must abandon it without a response.
        applyStimulus(4'(ALU_MUL), 32'd5, 32'd5, 32'd25, 1'b0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mulrst_req_ready", 32'(bus.req_ready), 32'd1);
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.rsp_valid) begin
                quiet = 1'b0;
            end
            @(negedge clk);
        end
        check("mulrst_no_rsp", 32'(quiet), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(4'(ALU_ADD), 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1);
        checkOutput(1, "post_reset_add");

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_resp.md
Name: alu_resp

Overview:
- Synthesizable ALU responder that serves operand requests (a, b, type) and returns a result c.
- It is the hardware counterpart of the operand-driving bench: the bench issues requests, and this block computes and returns results over a valid/ready handshake.
- Single-cycle logic/arithmetic ops, plus an iterative shift-add multiplier.
- Sits between a request generator/checker and any consumer of results; one request in flight at a time.

Parameters:
- WIDTH, 32, operand/result width in bits (power of 2, >= 8)
- SHW, $clog2(WIDTH), shift-amount width, derived; not overridden

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_a  in  WIDTH  operand a
- req_b  in  WIDTH  operand b
- req_type  in  4  operation code
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_c  out  WIDTH  result
- rsp_ovf  out  1  overflow flag
- rsp_err  out  1  illegal op code flag

Behaviour:
- Reset: state=IDLE; rsp_valid=0, rsp_c=0, rsp_ovf=0, rsp_err=0. req_ready=1 in the first cycle after reset. Reset mid-multiply abandons the operation, and no response is produced.
- Op codes:
  - 0 ADD: a+b
  - 1 SUB: a-b
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLL: a << b[SHW-1:0]
  - 6 SRL: logical a >> b[SHW-1:0]
  - 7 MUL: unsigned a*b, low WIDTH bits
  - 8-15: illegal; c=0, err=1, ovf=0
- Arithmetic: results truncate to WIDTH (wrap-around).
  - ADD/SUB ovf = signed two's-complement overflow.
  - MUL ovf = 1 iff the high WIDTH bits of the full product are nonzero.
  - Logic and shift ops: ovf=0.
- Handshake: a transfer occurs when valid&ready are both high on a rising edge. Inputs are sampled only on a request transfer. rsp_* stay stable while rsp_valid=1 and rsp_ready=0.
- FSM states: IDLE, MUL, DONE.
  - IDLE: req_ready=1.
    - Accept a non-MUL op: register the result, go to DONE. rsp_valid=1 in the cycle after acceptance (latency 1).
    - Accept MUL: load multiplicand/multiplier, clear accumulator and counter, go to MUL.
  - MUL: req_ready=0. One shift-add step per cycle for WIDTH cycles; counter counts 0..WIDTH-1. Final step writes rsp_c/rsp_ovf, then go to DONE. rsp_valid rises WIDTH+1 cycles after acceptance.
  - DONE: rsp_valid=1; req_ready = rsp_ready.
    - rsp_ready=0: hold.
    - rsp_ready=1 with no new request: go to IDLE, rsp_valid=0 next cycle.
    - rsp_ready=1 with req_valid=1 (simultaneous response+request): accept the new request in the same cycle.
      - Non-MUL: stay in DONE with the new result. This gives one result per cycle for back-to-back simple ops.
      - MUL: go to MUL, rsp_valid=0.
- req_ready is combinational from state and rsp_ready only; there is no path from req_valid to req_ready.
- Illegal op: follows the single-cycle path.

Decomposition:
- Package alu_resp_pkg:
  - op-code enum alu_op_e (ALU_ADD=0 .. ALU_MUL=7)
  - state enum alu_state_e {IDLE, MUL, DONE}
  - function is_legal_op()
  - shared by RTL and bench
- Sub-module alu_mul_seq: iterative shift-add multiplier.
  - Ports: start, a, b, busy, done, prod_lo, prod_hi.
  - The top holds the FSM and the single-cycle datapath.

Test Plan:
- ADD directed: a=3, b=5, type=0, rsp_ready=1 -> rsp_c=8, ovf=0, rsp_valid exactly 1 cycle after the accept.
- Overflow/wrap: ADD a=32'h7FFFFFFF, b=1 -> c=32'h80000000, ovf=1; SUB a=0, b=1 -> c=32'hFFFFFFFF, ovf=0.
- MUL latency: a=32'h10000, b=32'h10000 -> rsp_valid after 33 cycles, c=0, ovf=1; a=7, b=6 -> c=42, ovf=0; req_ready=0 throughout.
- Backpressure: hold rsp_ready=0 for 10 cycles after an XOR (a=32'hF0F0, b=32'hFFFF) result -> rsp_c=32'h0F0F stable, req_ready=0; release -> single transfer.
- Back-to-back streaming: 20 ADDs with a+=1, b+=2 starting at 0, req_valid and rsp_ready held at 1 -> one result per cycle, k-th result = 3k, no drops or duplicates.
- Illegal op + reset: type=12 -> c=0, err=1; assert rst during MUL cycle 10 -> no rsp_valid, req_ready=1 after reset, next ADD 1+1 returns 2.
